// File: rtl/vga_rd_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vga_rd_pkg
// Purpose  : Shared types and constants for the VGA FIFO refill controller:
//            scheduler state encoding, flush duration and counter widths.
// Revision : 1.0  initial release
// ============================================================================
package vga_rd_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FLUSH = 3'd1,
      CHECK = 3'd2,
      REQ   = 3'd3,
      BURST = 3'd4,
      DONE  = 3'd5
   } state_e;

   // Number of cycles the FIFO clear request is held high.
   localparam int FLUSH_CYC   = 2;
   localparam int FLUSH_CNT_W = 2;

   // Burst length field width (holds 1..256).
   localparam int LEN_W  = 9;

   // Frame word counters; wide enough for frames up to 16M words.
   localparam int WCNT_W = 24;

   // Width used for the FIFO fill-level headroom comparison.
   localparam int FILL_W = 12;

endpackage
`default_nettype wire

// File: rtl/vga_rd_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_rd_addr_gen
// Purpose  : Frame-buffer address generator for the VGA refill scheduler.
//            Holds the current burst start address and the words remaining in
//            the frame, derives the next burst length and selects the bank.
// Ports    : clk_sdram, rst        clock / async active-high reset
//            load                  start of frame: reload base and word count
//            advance               burst finished: step address and count
//            cam_frame_done        camera finished a bank (double buffer only)
//            addr, len             next burst start address and length
//            last_burst            the burst described by addr/len ends frame
//            rd_bank               bank currently displayed
// Config   : VGA_DOUBLE_BUFFER_EN enables bank swapping between BASE0/BASE1.
// Revision : 1.0  initial release
// ============================================================================
module vga_rd_addr_gen
   import vga_rd_pkg::*;
#(
   parameter int                ADDR_W      = 22,
   parameter int                BURST_LEN   = 256,
   parameter int                FRAME_WORDS = 307200,
   parameter logic [ADDR_W-1:0] BASE0       = '0,
   parameter logic [ADDR_W-1:0] BASE1       = ADDR_W'(32'h80000)
) (
   input  logic              clk_sdram,
   input  logic              rst,
   input  logic              load,
   input  logic              advance,
   input  logic              cam_frame_done,
   output logic [ADDR_W-1:0] addr,
   output logic [LEN_W-1:0]  len,
   output logic              last_burst,
   output logic              rd_bank
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WCNT_W-1:0] words_left_q, words_left_d;
   logic [ADDR_W-1:0] base;

`ifdef VGA_DOUBLE_BUFFER_EN
   logic bank_q, bank_d;
   logic swap_q, swap_d;

   // The swap request is consumed at the frame load; a camera completion in
   // the same cycle re-arms it for the following frame.
   always_comb begin
      bank_d = bank_q;
      swap_d = swap_q;
      if (load) begin
         bank_d = bank_q ^ swap_q;
         swap_d = 1'b0;
      end
      if (cam_frame_done) begin
         swap_d = 1'b1;
      end
   end

   always_ff @(posedge clk_sdram or posedge rst) begin
      if (rst) begin
         bank_q <= 1'b0;
         swap_q <= 1'b0;
      end else begin
         bank_q <= bank_d;
         swap_q <= swap_d;
      end
   end

   // Base follows the bank being selected by this load, not the old one.
   assign base    = bank_d ? BASE1 : BASE0;
   assign rd_bank = bank_q;
`else
   logic unused_db;
   assign unused_db = ^{cam_frame_done, BASE1};
   assign base      = BASE0;
   assign rd_bank   = 1'b0;
`endif

   // Burst length is the smaller of the maximum burst and what is left.
   always_comb begin
      if (words_left_q >= WCNT_W'(BURST_LEN)) begin
         len = LEN_W'(BURST_LEN);
      end else begin
         len = words_left_q[LEN_W-1:0];
      end
   end

   assign last_burst = (words_left_q == WCNT_W'(len));
   assign addr       = addr_q;

   always_comb begin
      addr_d       = addr_q;
      words_left_d = words_left_q;
      if (load) begin
         addr_d       = base;
         words_left_d = WCNT_W'(FRAME_WORDS);
      end else if (advance) begin
         // Wraps modulo 2^ADDR_W by construction.
         addr_d       = addr_q + ADDR_W'(len);
         words_left_d = words_left_q - WCNT_W'(len);
      end
   end

   always_ff @(posedge clk_sdram or posedge rst) begin
      if (rst) begin
         addr_q       <= BASE0;
         words_left_q <= '0;
      end else begin
         addr_q       <= addr_d;
         words_left_q <= words_left_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/vga_fifo_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_fifo_refill_ctrl
// Purpose  : Read scheduler in the clk_sdram domain that keeps the VGA output
//            FIFO fed from the SDRAM frame buffer. Issues burst reads when the
//            FIFO has room, forwards returned beats into the FIFO, flushes and
//            re-primes the FIFO every frame and raises wait_scrn once primed.
// Ports    : clk_sdram, rst                clock / async active-high reset
//            frame_start                   synchronised vsync pulse
//            fifo_wrusedw                  FIFO write-side fill level
//            fifo_aclr, wr_fifo, fifo_data FIFO clear / write interface
//            wait_scrn                     FIFO primed, scan-out may read
//            rd_req, rd_addr, rd_len,
//            rd_ack, rd_valid, rd_data     SDRAM burst read interface
//            cam_frame_done, rd_bank       double-buffer bank handshake
//            ovf_err                       sticky write-into-full-FIFO flag
// Config   : VGA_DOUBLE_BUFFER_EN enables bank swapping (in vga_rd_addr_gen).
// Revision : 1.0  initial release
// ============================================================================
module vga_fifo_refill_ctrl
   import vga_rd_pkg::*;
#(
   parameter int                ADDR_W      = 22,
   parameter int                BURST_LEN   = 256,
   parameter int                FIFO_DEPTH  = 1024,
   parameter int                PRIME_WORDS = 512,
   parameter int                FRAME_WORDS = 307200,
   parameter logic [ADDR_W-1:0] BASE0       = '0,
   parameter logic [ADDR_W-1:0] BASE1       = ADDR_W'(32'h80000)
) (
   input  logic              clk_sdram,
   input  logic              rst,
   input  logic              frame_start,
   input  logic [9:0]        fifo_wrusedw,
   output logic              fifo_aclr,
   output logic              wr_fifo,
   output logic [15:0]       fifo_data,
   output logic              wait_scrn,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [8:0]        rd_len,
   input  logic              rd_ack,
   input  logic              rd_valid,
   input  logic [15:0]       rd_data,
   input  logic              cam_frame_done,
   output logic              rd_bank,
   output logic              ovf_err
);

   state_e                 state_q, state_d;
   logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic                   pending_q, pending_d;
   logic [LEN_W-1:0]       beat_cnt_q, beat_cnt_d;
   logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
   logic                   wait_scrn_q, wait_scrn_d;
   logic                   fifo_aclr_q, fifo_aclr_d;
   logic                   wr_fifo_q, wr_fifo_d;
   logic [15:0]            fifo_data_q, fifo_data_d;
   logic                   rd_req_q, rd_req_d;
   logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
   logic [LEN_W-1:0]       rd_len_q, rd_len_d;
   logic                   ovf_err_q, ovf_err_d;

   logic                   load;
   logic                   advance;
   logic                   beat_fwd;
   logic [ADDR_W-1:0]      gen_addr;
   logic [LEN_W-1:0]       gen_len;
   logic                   gen_last;
   logic [FILL_W-1:0]      fill_sum;
   logic                   fits;

   vga_rd_addr_gen #(
      .ADDR_W      (ADDR_W),
      .BURST_LEN   (BURST_LEN),
      .FRAME_WORDS (FRAME_WORDS),
      .BASE0       (BASE0),
      .BASE1       (BASE1)
   ) u_addr_gen (
      .clk_sdram      (clk_sdram),
      .rst            (rst),
      .load           (load),
      .advance        (advance),
      .cam_frame_done (cam_frame_done),
      .addr           (gen_addr),
      .len            (gen_len),
      .last_burst     (gen_last),
      .rd_bank        (rd_bank)
   );

   // A burst is only requested when all of it is guaranteed to fit.
   assign fill_sum = FILL_W'(fifo_wrusedw) + FILL_W'(gen_len);
   assign fits     = (fill_sum <= FILL_W'(FIFO_DEPTH - 1));

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      pending_d   = pending_q;
      beat_cnt_d  = beat_cnt_q;
      wcnt_d      = wcnt_q;
      wait_scrn_d = wait_scrn_q;
      wr_fifo_d   = 1'b0;
      fifo_data_d = fifo_data_q;
      rd_addr_d   = rd_addr_q;
      rd_len_d    = rd_len_q;
      ovf_err_d   = ovf_err_q;
      load        = 1'b0;
      advance     = 1'b0;
      beat_fwd    = 1'b0;

      case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d = FLUSH;
            end
         end

         FLUSH: begin
            load        = (flush_cnt_q == '0);
            wcnt_d      = '0;
            pending_d   = 1'b0;
            flush_cnt_d = flush_cnt_q + 1'b1;
            if (flush_cnt_q == FLUSH_CNT_W'(FLUSH_CYC - 1)) begin
               state_d = CHECK;
            end
         end

         CHECK: begin
            if (frame_start) begin
               state_d = FLUSH;
            end else if (fits) begin
               // Command fields are captured here and held through REQ.
               state_d    = REQ;
               rd_addr_d  = gen_addr;
               rd_len_d   = gen_len;
               beat_cnt_d = '0;
            end
         end

         REQ: begin
            if (frame_start) begin
               pending_d = 1'b1;
            end
            if (rd_ack) begin
               state_d = BURST;
            end
         end

         BURST: begin
            if (frame_start) begin
               pending_d = 1'b1;
            end
            if (rd_valid) begin
               // Beats belonging to a frame that has already been superseded
               // are consumed from the controller but not written.
               beat_fwd   = !(pending_q || frame_start);
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == rd_len_q - 1'b1) begin
                  advance = 1'b1;
                  if (pending_q || frame_start) begin
                     state_d = FLUSH;
                  end else if (gen_last) begin
                     state_d = DONE;
                  end else begin
                     state_d = CHECK;
                  end
               end
            end
         end

         DONE: begin
            if (frame_start) begin
               state_d = FLUSH;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if ((state_d == FLUSH) && (state_q != FLUSH)) begin
         flush_cnt_d = '0;
      end

      if (beat_fwd) begin
         wr_fifo_d   = 1'b1;
         fifo_data_d = rd_data;
         wcnt_d      = wcnt_q + 1'b1;
         if (fifo_wrusedw == 10'(FIFO_DEPTH - 1)) begin
            ovf_err_d = 1'b1;
         end
      end

      if (state_q == FLUSH) begin
         wait_scrn_d = 1'b0;
      end else if (state_q != IDLE) begin
         if (wcnt_d >= WCNT_W'(PRIME_WORDS)) begin
            wait_scrn_d = 1'b1;
         end else if ((state_q == DONE) && (FRAME_WORDS < PRIME_WORDS)) begin
            wait_scrn_d = 1'b1;
         end
      end

      // Registered Moore decodes of the next state keep these glitch-free.
      fifo_aclr_d = (state_d == FLUSH);
      rd_req_d    = (state_d == REQ);
   end

   always_ff @(posedge clk_sdram or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         flush_cnt_q <= '0;
         pending_q   <= 1'b0;
         beat_cnt_q  <= '0;
         wcnt_q      <= '0;
         wait_scrn_q <= 1'b0;
         fifo_aclr_q <= 1'b0;
         wr_fifo_q   <= 1'b0;
         fifo_data_q <= '0;
         rd_req_q    <= 1'b0;
         rd_addr_q   <= '0;
         rd_len_q    <= '0;
         ovf_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         pending_q   <= pending_d;
         beat_cnt_q  <= beat_cnt_d;
         wcnt_q      <= wcnt_d;
         wait_scrn_q <= wait_scrn_d;
         fifo_aclr_q <= fifo_aclr_d;
         wr_fifo_q   <= wr_fifo_d;
         fifo_data_q <= fifo_data_d;
         rd_req_q    <= rd_req_d;
         rd_addr_q   <= rd_addr_d;
         rd_len_q    <= rd_len_d;
         ovf_err_q   <= ovf_err_d;
      end
   end

   assign fifo_aclr = fifo_aclr_q;
   assign wr_fifo   = wr_fifo_q;
   assign fifo_data = fifo_data_q;
   assign wait_scrn = wait_scrn_q;
   assign rd_req    = rd_req_q;
   assign rd_addr   = rd_addr_q;
   assign rd_len    = rd_len_q;
   assign ovf_err   = ovf_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_fifo_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fifo_refill_ctrl
// Purpose  : Self-checking bench for vga_fifo_refill_ctrl with a small frame
//            (20 words, 8-word bursts, prime at 8 words). Plays the SDRAM
//            controller with random data/gaps and compares against a frame
//            level model (burst list, expected FIFO contents, bank choice).
// Config   : VGA_DOUBLE_BUFFER_EN selects the double-buffer expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_fifo_refill_ctrl;

   localparam int          ADDR_W = 22;
   localparam int          BURST  = 8;
   localparam int          FRAME  = 20;
   localparam int          PRIME  = 8;
   localparam int          DEPTH  = 1024;
   localparam int          NREQ   = (FRAME + BURST - 1) / BURST;
   localparam logic [21:0] B0     = 22'h100;
   localparam logic [21:0] B1     = 22'h800;
`ifdef VGA_DOUBLE_BUFFER_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif

   logic              clk_sdram = 1'b0;
   logic              rst = 1'b1;
   logic              frame_start = 1'b0;
   logic [9:0]        fifo_wrusedw = '0;
   logic              fifo_aclr;
   logic              wr_fifo;
   logic [15:0]       fifo_data;
   logic              wait_scrn;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [8:0]        rd_len;
   logic              rd_ack = 1'b0;
   logic              rd_valid = 1'b0;
   logic [15:0]       rd_data = '0;
   logic              cam_frame_done = 1'b0;
   logic              rd_bank;
   logic              ovf_err;

   vga_fifo_refill_ctrl #(
      .ADDR_W      (ADDR_W),
      .BURST_LEN   (BURST),
      .FIFO_DEPTH  (DEPTH),
      .PRIME_WORDS (PRIME),
      .FRAME_WORDS (FRAME),
      .BASE0       (B0),
      .BASE1       (B1)
   ) dut (
      .clk_sdram      (clk_sdram),
      .rst            (rst),
      .frame_start    (frame_start),
      .fifo_wrusedw   (fifo_wrusedw),
      .fifo_aclr      (fifo_aclr),
      .wr_fifo        (wr_fifo),
      .fifo_data      (fifo_data),
      .wait_scrn      (wait_scrn),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .rd_len         (rd_len),
      .rd_ack         (rd_ack),
      .rd_valid       (rd_valid),
      .rd_data        (rd_data),
      .cam_frame_done (cam_frame_done),
      .rd_bank        (rd_bank),
      .ovf_err        (ovf_err)
   );

   always #5 clk_sdram = ~clk_sdram;

   int          checks = 0;
   int          failures = 0;
   int          writes = 0;
   int          aclr_cycles = 0;
   int          req_idx = 0;
   logic [15:0] exp_q[$];
   logic        exp_bank = 1'b0;
   logic        exp_swap = 1'b0;
   logic        exp_ovf = 1'b0;
   logic        prime_armed = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock; samples 1 time unit after the rising edge and tracks FIFO side.
   task automatic tick();
      int prev_w;
      @(posedge clk_sdram);
      #1;
      if (fifo_aclr) begin
         aclr_cycles++;
         writes      = 0;
         prime_armed = 1'b1;
      end
      prev_w = writes;
      if (wr_fifo) begin
         writes++;
         if (exp_q.size() == 0) chk("unexpected_write", 32'(wr_fifo), 32'd0);
         else                   chk("fifo_data", 32'(fifo_data), 32'(exp_q.pop_front()));
      end
      if (prime_armed && !fifo_aclr) begin
         if (writes < PRIME)       chk("wait_scrn_early", 32'(wait_scrn), 32'd0);
         else if (prev_w >= PRIME) chk("wait_scrn_primed", 32'(wait_scrn), 32'd1);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_aclr"},  32'(fifo_aclr), 32'd0);
      chk({tag, "_wr"},    32'(wr_fifo),   32'd0);
      chk({tag, "_data"},  32'(fifo_data), 32'd0);
      chk({tag, "_wait"},  32'(wait_scrn), 32'd0);
      chk({tag, "_req"},   32'(rd_req),    32'd0);
      chk({tag, "_addr"},  32'(rd_addr),   32'd0);
      chk({tag, "_len"},   32'(rd_len),    32'd0);
      chk({tag, "_bank"},  32'(rd_bank),   32'd0);
      chk({tag, "_ovf"},   32'(ovf_err),   32'd0);
   endtask

   task automatic model_new_frame();
      if (exp_swap) begin
         exp_bank = ~exp_bank;
         exp_swap = 1'b0;
      end
      req_idx = 0;
   endtask

   task automatic start_frame(input int fill);
      model_new_frame();
      fifo_wrusedw = 10'(fill);
      frame_start  = 1'b1;
      tick();
      frame_start  = 1'b0;
      chk("aclr_after_frame_start", 32'(fifo_aclr), 32'd1);
   endtask

   // Acts as the SDRAM controller for one command. drop_at: beat index that
   // coincides with a new frame_start (-1 none). rst_at: beat index at which
   // reset is applied instead of the beat (-1 none).
   task automatic serve(input int ack_delay, input int drop_at, input bit ovf_fill, input int rst_at);
      logic [21:0] ea;
      logic [8:0]  el;
      logic [15:0] d;
      logic [9:0]  saved_fill;
      int          waited;
      int          gap;
      ea = (exp_bank ? B1 : B0) + 22'(BURST * req_idx);
      el = 9'(((FRAME - BURST * req_idx) < BURST) ? (FRAME - BURST * req_idx) : BURST);
      waited = 0;
      while (!rd_req && waited < 40) begin
         tick();
         waited++;
      end
      chk("req_seen", 32'(rd_req), 32'd1);
      if (!rd_req) return;
      chk("rd_addr", 32'(rd_addr), 32'(ea));
      chk("rd_len",  32'(rd_len),  32'(el));
      for (int i = 0; i < ack_delay; i++) begin
         tick();
         chk("req_hold",  32'(rd_req),  32'd1);
         chk("addr_hold", 32'(rd_addr), 32'(ea));
         chk("len_hold",  32'(rd_len),  32'(el));
      end
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      chk("req_low_after_ack", 32'(rd_req), 32'd0);
      req_idx++;
      saved_fill = fifo_wrusedw;
      if (ovf_fill) fifo_wrusedw = 10'(DEPTH - 1);
      for (int b = 0; b < int'(el); b++) begin
         gap = $urandom_range(0, 2);
         repeat (gap) tick();
         if (b == rst_at) begin
            rst = 1'b1;
            #1;
            check_all_zero("rst_async");
            tick();
            check_all_zero("rst_edge");
            rst = 1'b0;
            exp_q.delete();
            exp_ovf     = 1'b0;
            exp_bank    = 1'b0;
            exp_swap    = 1'b0;
            prime_armed = 1'b0;
            fifo_wrusedw = saved_fill;
            return;
         end
         d        = 16'($urandom);
         rd_valid = 1'b1;
         rd_data  = d;
         if (b == drop_at) frame_start = 1'b1;
         if (!(drop_at >= 0 && b >= drop_at)) begin
            exp_q.push_back(d);
            if (ovf_fill) exp_ovf = 1'b1;
         end
         tick();
         rd_valid    = 1'b0;
         frame_start = 1'b0;
      end
      fifo_wrusedw = saved_fill;
      chk("ovf_err", 32'(ovf_err), 32'(exp_ovf));
   endtask

   task automatic frame_end_check(input string tag);
      repeat (3) tick();
      chk({tag, "_done_no_req"}, 32'(rd_req), 32'd0);
      chk({tag, "_writes"},      32'(writes), 32'(FRAME));
      chk({tag, "_wait_scrn"},   32'(wait_scrn), 32'd1);
      chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic serve_frame(input string tag);
      for (int r = 0; r < NREQ; r++) serve(0, -1, 1'b0, -1);
      frame_end_check(tag);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk_sdram);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      tick();
      check_all_zero("post_reset_idle");

      // Basic frame: three bursts, 20 writes, 2-cycle clear
      aclr_cycles = 0;
      start_frame($urandom_range(0, 900));
      serve_frame("basic");
      chk("basic_aclr_cycles", 32'(aclr_cycles), 32'd2);

      // Backpressure around the headroom boundary
      start_frame(1020);
      repeat (6) begin
         tick();
         chk("bp_no_req_1020", 32'(rd_req), 32'd0);
      end
      fifo_wrusedw = 10'd1016;
      repeat (3) begin
         tick();
         chk("bp_no_req_1016", 32'(rd_req), 32'd0);
      end
      fifo_wrusedw = 10'd1015;
      tick();
      chk("bp_req_at_1015", 32'(rd_req), 32'd1);
      serve_frame("bp");

      // frame_start coincident with the 4th beat of the first burst
      aclr_cycles = 0;
      start_frame($urandom_range(0, 900));
      serve(0, 3, 1'b0, -1);
      model_new_frame();
      serve_frame("midburst");
      chk("midburst_aclr_cycles", 32'(aclr_cycles), 32'd4);

      // Delayed acknowledge, then an overflowing final burst
      start_frame($urandom_range(0, 900));
      serve(5, -1, 1'b0, -1);
      serve(0, -1, 1'b0, -1);
      serve(0, -1, 1'b1, -1);
      frame_end_check("hold");

      // Reset in the middle of a burst, then stray beats
      start_frame($urandom_range(0, 900));
      serve(0, -1, 1'b0, 2);
      rd_valid = 1'b1;
      repeat (3) begin
         rd_data = 16'($urandom);
         tick();
         chk("stray_no_write", 32'(wr_fifo), 32'd0);
         chk("stray_no_req",   32'(rd_req),  32'd0);
      end
      rd_valid = 1'b0;

      // Bank selection
      cam_frame_done = 1'b1;
      tick();
      cam_frame_done = 1'b0;
      if (DB) exp_swap = 1'b1;
      start_frame($urandom_range(0, 900));
      serve_frame("bank_a");
      chk("rd_bank_a", 32'(rd_bank), 32'(exp_bank));
      start_frame($urandom_range(0, 900));
      serve_frame("bank_b");
      chk("rd_bank_b", 32'(rd_bank), 32'(exp_bank));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired before completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
